// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-bank responder: NUM_REGS word registers with independent
// write (AW/W/B) and read (AR/R) paths, exported contents and write strobes.
module axi_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [1:0]                     BRESP,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_stb
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int SW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'b00,
    W_HAVE_AW = 2'b01,
    W_HAVE_W  = 2'b10,
    W_RESP    = 2'b11
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_t;

  // Byte address bits [1:0] never take part in decode.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:2] < IW'(NUM_REGS);
  endfunction

  function automatic logic [SW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[SW+1:2];
  endfunction

  wstate_t                              r_wstate;
  wstate_t                              w_wstate_nxt;
  rstate_t                              r_rstate;
  rstate_t                              w_rstate_nxt;
  logic                                 r_awready;
  logic                                 r_wready;
  logic                                 r_bvalid;
  logic [1:0]                           r_bresp;
  logic                                 r_arready;
  logic                                 r_rvalid;
  logic [DATA_WIDTH-1:0]                r_rdata;
  logic [1:0]                           r_rresp;
  logic [ADDR_WIDTH-1:0]                r_awaddr;
  logic [DATA_WIDTH-1:0]                r_wdata;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  r_regs;
  logic [NUM_REGS-1:0]                  r_wr_stb;
  logic                                 w_aw_hs;
  logic                                 w_w_hs;
  logic                                 w_ar_hs;
  logic                                 w_wr_fire;
  logic [ADDR_WIDTH-1:0]                w_wr_addr;
  logic [DATA_WIDTH-1:0]                w_wr_data;

  assign w_aw_hs = AWVALID & r_awready;
  assign w_w_hs  = WVALID  & r_wready;
  assign w_ar_hs = ARVALID & r_arready;

  // Write FSM next state; the completing beat comes from the bus, the other from the buffer.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_fire    = 1'b0;
    w_wr_addr    = (r_wstate == W_HAVE_AW) ? r_awaddr : AWADDR;
    w_wr_data    = (r_wstate == W_HAVE_W)  ? r_wdata  : WDATA;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_wr_fire    = 1'b1;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_HAVE_W;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_HAVE_AW: begin
        if (w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_wr_fire    = 1'b1;
        end else begin
          w_wstate_nxt = W_HAVE_AW;
        end
      end
      W_HAVE_W: begin
        if (w_aw_hs) begin
          w_wstate_nxt = W_RESP;
          w_wr_fire    = 1'b1;
        end else begin
          w_wstate_nxt = W_HAVE_W;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_wstate_nxt = W_IDLE;
        end else begin
          w_wstate_nxt = W_RESP;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write path state, registered handshake outputs, beat buffers and register bank.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_regs    <= '0;
      r_wr_stb  <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_W);
      r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_AW);
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      r_wr_stb  <= '0;
      if (w_aw_hs) begin
        r_awaddr <= AWADDR;
      end
      if (w_w_hs) begin
        r_wdata <= WDATA;
      end
      if (w_wr_fire) begin
        r_bresp <= addr_ok(w_wr_addr) ? RESP_OKAY : RESP_SLVERR;
        if (addr_ok(w_wr_addr)) begin
          r_regs[addr_idx(w_wr_addr)]   <= w_wr_data;
          r_wr_stb[addr_idx(w_wr_addr)] <= 1'b1;
        end
      end
    end
  end

  // Read FSM next state.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt = R_RESP;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_RESP: begin
        if (RREADY) begin
          w_rstate_nxt = R_IDLE;
        end else begin
          w_rstate_nxt = R_RESP;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read path; capturing from r_regs yields the pre-write value on a same-edge collision.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_RESP);
      if (w_ar_hs) begin
        r_rdata <= addr_ok(ARADDR) ? r_regs[addr_idx(ARADDR)] : '0;
        r_rresp <= addr_ok(ARADDR) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign AWREADY    = r_awready;
  assign WREADY     = r_wready;
  assign BVALID     = r_bvalid;
  assign BRESP      = r_bresp;
  assign ARREADY    = r_arready;
  assign RVALID     = r_rvalid;
  assign RDATA      = r_rdata;
  assign RRESP      = r_rresp;
  assign reg_q      = r_regs;
  assign reg_wr_stb = r_wr_stb;

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite responder (subordinate) that terminates the bus driven by the verification driver. It implements a bank of NUM_REGS word-addressed read/write registers. Register contents are exported to the surrounding fabric, with a one-cycle write strobe per register. It is the DUT-side counterpart of the driver/monitor environment and uses the same AXI4-Lite channel subset (no WSTRB, no PROT).

Parameters:
ADDR_WIDTH, 32, AWADDR/ARADDR width
DATA_WIDTH, 32, register and data bus width
NUM_REGS, 8, number of registers (>=1); register i sits at byte address 4*i

Ports:
ACLK  input  1  clock, all logic on rising edge
ARESET  input  1  synchronous active-high reset
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
AWADDR  input  ADDR_WIDTH  write byte address
WVALID  input  1  write data valid
WREADY  output  1  write data ready
WDATA  input  DATA_WIDTH  write data
BVALID  output  1  write response valid
BREADY  input  1  write response ready
BRESP  output  2  write response (00 OKAY, 10 SLVERR)
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
ARADDR  input  ADDR_WIDTH  read byte address
RVALID  output  1  read data valid
RREADY  input  1  read data ready
RDATA  output  DATA_WIDTH  read data
RRESP  output  2  read response (00 OKAY, 10 SLVERR)
reg_q  output  NUM_REGS*DATA_WIDTH  register contents, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr_stb  output  NUM_REGS  one-cycle pulse, bit i set the cycle after reg i is written

Behaviour:
- Single clock ACLK; reset is synchronous and active-high (ARESET), sampled on the rising edge.
- Reset: AWREADY=0, WREADY=0, BVALID=0, BRESP=00, ARREADY=0, RVALID=0, RDATA=0, RRESP=00, reg_q=0, reg_wr_stb=0. All held address/data buffers are cleared.
- Reset mid-transaction: the pending AW/W/B/AR/R state is discarded and no register write occurs. The first cycle after reset deasserts is a normal idle cycle.
- Decode: index = addr[ADDR_WIDTH-1:2]; addr[1:0] are ignored. index < NUM_REGS gives OKAY; otherwise SLVERR.
- Write path states: IDLE, HAVE_AW, HAVE_W, RESP.
  - AWREADY = 1 in IDLE/HAVE_W. WREADY = 1 in IDLE/HAVE_AW. Both are 0 in RESP and during reset. These are registered outputs.
  - AW and W are accepted independently, in either order or in the same cycle. The first accepted beat is buffered and the state moves to HAVE_AW or HAVE_W.
  - At the edge where the second beat completes (or both complete together from IDLE): the register is written if in range, BRESP is set, BVALID=1 and the state moves to RESP. reg_wr_stb[index] pulses during the following cycle, in range only.
  - Latency: AW+W in the same cycle at edge k gives BVALID high after edge k.
  - BVALID, BRESP are held stable until BREADY=1. On the BVALID&&BREADY edge the state returns to IDLE and BVALID=0. A new AW/W cannot be accepted in that same edge.
  - Out-of-range write: no register changes, no strobe, BRESP=10.
- Read path states: R_IDLE, R_RESP.
  - ARREADY = 1 only in R_IDLE.
  - On the ARVALID&&ARREADY edge: RDATA = reg[index] (or 0 if out of range), RRESP = 00 or 10, RVALID=1, state moves to R_RESP. ARREADY drops.
  - RVALID/RDATA/RRESP are held until RREADY. On the handshake edge RVALID=0, RDATA keeps its value, and the state returns to R_IDLE.
- Read and write paths are fully independent and may complete on the same edge.
- Same-edge collision: an AR capture and a write to the same register on one edge returns the old (pre-write) value.
- No ordering is enforced between the read and write channels.
- Inputs are not required to stay stable without VALID. Only the values present at the handshake edge matter.

Test Plan:
- Reset then idle: after ARESET=1 for 2 cycles -> all outputs 0; first cycle after release -> AWREADY=WREADY=ARREADY=1, reg_q=0.
- Write AW+W same cycle, AWADDR=0x8, WDATA=0xDEADBEEF, BREADY=1 -> BVALID next cycle with BRESP=00, reg_q word 2 = 0xDEADBEEF, reg_wr_stb=0b00000100 for one cycle. Then ARADDR=0x8 -> RDATA=0xDEADBEEF, RRESP=00.
- W before AW: WDATA=0x1234 at cycle 1, AWADDR=0x4 at cycle 4 -> WREADY=0 during cycles 2-4; BVALID after the cycle-4 edge; reg1=0x1234.
- Backpressure: BREADY=0 for 5 cycles after a write -> BVALID and BRESP stay stable, AWREADY=WREADY=0 throughout. Raise BREADY -> BVALID drops, AWREADY=1 the next cycle. Repeat with RREADY=0 on a read -> RDATA held, ARREADY=0.
- Out of range: write AWADDR=0x20 with NUM_REGS=8 -> BRESP=10, no reg_q change, no strobe. Read ARADDR=0x3C -> RDATA=0, RRESP=10.
- Reset mid-op: AW accepted, ARESET pulsed before W -> no register write. A later W alone stays buffered with no BVALID until a new AW arrives.
